// File: rtl/inst_fetch_axi.sv
// Instruction fetch: holds the PC and reads one 32-bit word per instruction over an AXI4-Lite read port.
// Latency: zero-wait slave gives AR on E1, R and presentation on E2, then one instruction every 2 cycles.
// Backpressure: stall_i freezes decode-side outputs; R data taken while stalled is parked in a one-word buffer.
module inst_fetch_axi #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_data_o,
    output logic        inst_valid_o,
    output logic        fetch_err_o,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] hold_data;
    logic        hold_err;

    logic        rd_hs;
    logic        rd_err;
    logic [31:0] rd_word;
    logic        pres_fire;
    logic [31:0] pres_word;
    logic        pres_err;

    // Instruction side of the bus is always tagged as an instruction access.
    assign m_arprot = 3'b100;

    // Decode the R beat and pick what gets presented: the live beat in DATA or the parked word in HOLD.
    always_comb begin
        rd_hs     = m_rvalid & m_rready;
        rd_err    = (m_rresp != 2'b00);
        rd_word   = rd_err ? 32'h0 : m_rdata;
        pres_fire = !stall_i && (((state == DATA) && rd_hs) || (state == HOLD));
        pres_word = (state == HOLD) ? hold_data : rd_word;
        pres_err  = (state == HOLD) ? hold_err  : rd_err;
    end

    // Fetch FSM, PC, stall buffer and the registered decode/AXI outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            hold_data    <= 32'h0;
            hold_err     <= 1'b0;
            m_arvalid    <= 1'b0;
            m_araddr     <= 32'h0;
            m_rready     <= 1'b0;
            inst_addr_o  <= 32'h0;
            inst_data_o  <= 32'h0;
            inst_valid_o <= 1'b0;
            fetch_err_o  <= 1'b0;
        end else begin
            // Unstalled edges default to a bubble; a presentation below overrides it.
            if (!stall_i) begin
                inst_valid_o <= 1'b0;
                inst_data_o  <= 32'h0;
                fetch_err_o  <= 1'b0;
            end
            if (pres_fire) begin
                // Present the word at pc and issue the next AR on the same edge.
                inst_addr_o  <= pc;
                inst_data_o  <= pres_word;
                inst_valid_o <= 1'b1;
                fetch_err_o  <= pres_err;
                pc           <= pc + 32'd4;
                m_arvalid    <= 1'b1;
                m_araddr     <= pc + 32'd4;
                m_rready     <= 1'b0;
                state        <= ADDR;
            end else begin
                case (state)
                    IDLE: begin
                        m_arvalid <= 1'b1;
                        m_araddr  <= pc;
                        state     <= ADDR;
                    end
                    ADDR: begin
                        if (m_arvalid && m_arready) begin
                            m_arvalid <= 1'b0;
                            m_rready  <= 1'b1;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        // Reaching here with a beat means decode is stalled: park it.
                        if (rd_hs) begin
                            m_rready  <= 1'b0;
                            hold_data <= rd_word;
                            hold_err  <= rd_err;
                            state     <= HOLD;
                        end
                    end
                    default: begin
                        // HOLD while stalled: nothing moves until stall_i drops.
                        state <= HOLD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Bench for inst_fetch_axi: randomized AXI4-Lite slave, random stalls, scoreboard of presented instructions.
// Expected stream is RESET_PC, +4, +8 ... with data = addr ^ A5A5_0000, or 0 with error flag on error addresses.
// A separate monitor pops the scoreboard on every fresh presentation and checks hold/bubble/AR rules.
module tb_inst_fetch_axi;

    localparam logic [31:0] RPC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_i = 1'b0;
    logic [31:0] inst_addr_o, inst_data_o;
    logic        inst_valid_o, fetch_err_o;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid, m_rready;

    inst_fetch_axi #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst_n), .stall_i(stall_i),
        .inst_addr_o(inst_addr_o), .inst_data_o(inst_data_o),
        .inst_valid_o(inst_valid_o), .fetch_err_o(fetch_err_o),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pres   = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Addresses whose word index mod 16 is 5 (e.g. 0x14, 0x114) answer with an error response.
    function automatic logic is_err(input logic [31:0] a);
        return (a[5:2] == 4'd5);
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Slave knobs and state
    int          ar_wait_max = 0;
    int          r_wait_max  = 0;
    int          ar_wait = 0;
    int          r_wait  = 0;
    logic        pending = 1'b0;
    logic [31:0] model_ar = RPC;
    logic [31:0] addr_l = 32'h0;
    logic [31:0] slv_addr = 32'h0;
    logic        s_ar_hs, s_r_hs;
    logic [31:0] s_araddr;

    // AXI4-Lite slave with random wait states; pushes the expected instruction when it delivers an R beat.
    initial begin : slave
        exp_t e;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
        forever begin
            @(negedge clk);
            s_ar_hs  = m_arvalid && m_arready;
            s_r_hs   = m_rvalid && m_rready;
            s_araddr = m_araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_arready = 1'b0; m_rvalid = 1'b0; pending = 1'b0;
                model_ar = RPC; ar_wait = 0; r_wait = 0;
                sb.delete();
                continue;
            end
            if (s_r_hs) begin
                e.addr = addr_l;
                e.data = is_err(addr_l) ? 32'h0 : word_of(addr_l);
                e.err  = is_err(addr_l);
                sb.push_back(e);
                m_rvalid = 1'b0;
                m_rdata  = $urandom;
                pending  = 1'b0;
            end
            if (s_ar_hs) begin
                chk("ar_addr", s_araddr, model_ar);
                addr_l   = model_ar;
                slv_addr = s_araddr;
                model_ar = model_ar + 32'd4;
                pending  = 1'b1;
                m_arready = 1'b0;
                ar_wait  = $urandom_range(0, ar_wait_max);
                r_wait   = $urandom_range(0, r_wait_max);
            end
            if (m_arvalid && !m_arready && !pending) begin
                if (ar_wait == 0) m_arready = 1'b1;
                else ar_wait--;
            end
            if (pending && !m_rvalid) begin
                if (r_wait == 0) begin
                    m_rvalid = 1'b1;
                    if (is_err(slv_addr)) begin
                        m_rresp = 2'($urandom_range(2, 3));
                        m_rdata = 32'hDEAD_BEEF;
                    end else begin
                        m_rresp = 2'b00;
                        m_rdata = word_of(slv_addr);
                    end
                end else begin
                    r_wait--;
                end
            end
        end
    end

    // Monitor: previous-cycle snapshot is what the DUT sampled on the edge just passed.
    logic        p_stall = 1'b0, p_arvalid = 1'b0, p_arready = 1'b0;
    logic [31:0] p_araddr = 32'h0, p_addr = 32'h0, p_data = 32'h0;
    logic        p_valid = 1'b0, p_err = 1'b0;
    logic        ar_seen = 1'b0;

    initial begin : monitor
        exp_t e;
        logic pres;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_addr", inst_addr_o, 32'h0);
                chk("rst_data", inst_data_o, 32'h0);
                chk("rst_flags", {inst_valid_o, fetch_err_o, m_arvalid, m_rready}, 32'h0);
                chk("rst_araddr", m_araddr, 32'h0);
                p_stall = stall_i; p_arvalid = 1'b0; p_arready = 1'b0; p_araddr = 32'h0;
                p_addr = 32'h0; p_data = 32'h0; p_valid = 1'b0; p_err = 1'b0;
                ar_seen = 1'b0;
                continue;
            end
            pres = 1'b0;
            if (p_stall) begin
                chk("stall_hold_addr", inst_addr_o, p_addr);
                chk("stall_hold_data", inst_data_o, p_data);
                chk("stall_hold_flags", {inst_valid_o, fetch_err_o}, {p_valid, p_err});
            end else if (inst_valid_o) begin
                pres = 1'b1;
                n_pres++;
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_underflow: presented %h with nothing expected at %0t", inst_addr_o, $time);
                end else begin
                    e = sb.pop_front();
                    chk("pres_addr", inst_addr_o, e.addr);
                    chk("pres_data", inst_data_o, e.data);
                    chk("pres_err", fetch_err_o, e.err);
                end
            end else begin
                chk("bubble_data", inst_data_o, 32'h0);
                chk("bubble_err", fetch_err_o, 32'h0);
                chk("bubble_addr_hold", inst_addr_o, p_addr);
            end
            if (m_arvalid && !p_arvalid) begin
                chk("ar_only_with_present", pres || !ar_seen, 32'h1);
                ar_seen = 1'b1;
            end
            if (p_arvalid && !p_arready) begin
                chk("ar_valid_stable", m_arvalid, 32'h1);
                chk("ar_addr_stable", m_araddr, p_araddr);
            end
            chk("one_outstanding", m_arvalid && m_rready, 32'h0);
            chk("arprot", m_arprot, 32'h4);
            p_stall = stall_i; p_arvalid = m_arvalid; p_arready = m_arready; p_araddr = m_araddr;
            p_addr = inst_addr_o; p_data = inst_data_o; p_valid = inst_valid_o; p_err = fetch_err_o;
        end
    end

    // Main sequence: boot timing, wait states, random stalls, mid-transaction reset.
    initial begin : main
        int k;
        int stall_cnt;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Boot with a zero-wait slave; also walks across the 32-bit wrap.
        @(posedge clk); #1;
        chk("e0_arvalid", m_arvalid, 32'h1);
        chk("e0_araddr", m_araddr, RPC);
        @(posedge clk); #1;
        chk("e1_rready", m_rready, 32'h1);
        chk("e1_valid", inst_valid_o, 32'h0);
        @(posedge clk); #1;
        chk("e2_valid", inst_valid_o, 32'h1);
        chk("e2_addr", inst_addr_o, RPC);
        chk("e2_data", inst_data_o, word_of(RPC));
        chk("e2_araddr", m_araddr, RPC + 32'd4);
        @(posedge clk); #1;
        chk("e3_bubble", {inst_valid_o, inst_data_o}, 32'h0);
        @(posedge clk); #1;
        chk("e4_valid", inst_valid_o, 32'h1);
        chk("e4_addr", inst_addr_o, 32'hFFFF_FFFC);
        chk("e4_araddr_wrap", m_araddr, 32'h0);
        @(posedge clk); #1;
        chk("e5_valid", inst_valid_o, 32'h0);
        @(posedge clk); #1;
        chk("e6_addr_wrap", inst_addr_o, 32'h0);
        chk("e6_data", inst_data_o, 32'hA5A5_0000);
        repeat (30) @(posedge clk);

        // Wait states on both channels, no stall.
        ar_wait_max = 3;
        r_wait_max  = 4;
        repeat (200) @(posedge clk);

        // Random stall bursts on top of wait states.
        stall_cnt = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (stall_cnt > 0) begin
                stall_i = 1'b1;
                stall_cnt--;
            end else if ($urandom_range(0, 5) == 0) begin
                stall_i = 1'b1;
                stall_cnt = $urandom_range(0, 4);
            end else begin
                stall_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        stall_i = 1'b0;

        // Reset while a read is outstanding in DATA.
        ar_wait_max = 0;
        r_wait_max  = 2;
        k = 0;
        while (!(m_rready && !m_rvalid) && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        chk("saw_data_state", m_rready, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_arvalid", m_arvalid, 32'h0);
        chk("async_rready", m_rready, 32'h0);
        chk("async_valid", inst_valid_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("restart_arvalid", m_arvalid, 32'h1);
        chk("restart_araddr", m_araddr, RPC);
        repeat (80) @(posedge clk);

        @(negedge clk); #1;
        chk("sb_drained", sb.size(), 32'h0);
        chk("presented_enough", n_pres > 60, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_axi.md
# inst_fetch_axi

Instruction fetch stage feeding the decode stage. It holds the PC and fetches one 32-bit instruction at a time over an AXI4-Lite read-only master port. It presents `inst_addr_o`/`inst_data_o` to decode through an output register that honours the pipeline stall. When no instruction is ready it inserts NOP bubbles (`inst_valid_o`=0, data 0).

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; first fetch address.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall_i`  in  1  pipeline stall from control; 1 = hold decode-side outputs.
- `inst_addr_o`  out  32  address of presented instruction.
- `inst_data_o`  out  32  presented instruction word (0 = NOP on bubble/error).
- `inst_valid_o`  out  1  presented instruction is real.
- `fetch_err_o`  out  1  one-cycle flag: presented instruction came back with RRESP≠OKAY.
- `m_araddr`  out  32  AR address.
- `m_arprot`  out  3  constant 3'b100 (instruction access).
- `m_arvalid`  out  1  AR valid.
- `m_arready`  in  1  AR ready.
- `m_rdata`  in  32  R data.
- `m_rresp`  in  2  R response.
- `m_rvalid`  in  1  R valid.
- `m_rready`  out  1  R ready.

## Operation
- Internal state: `pc` (32b), `buf` (32b data + 1b err), FSM {IDLE, ADDR, DATA, HOLD}.
- All outputs are registered except the constant `m_arprot`.
- **Reset (rst=0, async):**
  - state=IDLE, pc=RESET_PC.
  - m_arvalid=0, m_araddr=0, m_rready=0.
  - inst_addr_o=0, inst_data_o=0, inst_valid_o=0, fetch_err_o=0.
  - Any outstanding transaction is abandoned; the slave shares the same reset.
- **IDLE:** next edge: m_arvalid<=1, m_araddr<=pc, go ADDR.
- **ADDR:**
  - m_arvalid and m_araddr stay stable until m_arvalid&m_arready is sampled.
  - On handshake: m_arvalid<=0, m_rready<=1, go DATA.
- **DATA:** on m_rvalid&m_rready, with err=(m_rresp≠2'b00) and word=err?0:m_rdata, m_rready<=0 and:
  - stall_i=0: inst_addr_o<=pc, inst_data_o<=word, inst_valid_o<=1, fetch_err_o<=err; pc<=pc+4; m_arvalid<=1, m_araddr<=pc+4; go ADDR.
  - stall_i=1: buf<={word,err}; outputs unchanged; go HOLD.
- **HOLD:**
  - stall_i=1: everything holds; no AR is issued.
  - stall_i=0: present buf at pc exactly as in the DATA/stall_i=0 case; pc<=pc+4; issue AR for pc+4; go ADDR.
- **Bubble:** on any edge with stall_i=0 and no instruction presented on that edge: inst_valid_o<=0, inst_data_o<=0, fetch_err_o<=0, inst_addr_o holds.
- **Stalled edges:** on any edge with stall_i=1, all decode-side outputs hold, including fetch_err_o and inst_valid_o.
- **Bus independence:** stall_i never affects AR/R signalling in ADDR or DATA.
- **PC arithmetic:** modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. No alignment check.
- At most one outstanding read; exactly one AR is issued per instruction presented.

## Timing
- E0 = first rising edge with rst=1 → m_arvalid=1, m_araddr=RESET_PC.
- Zero-wait slave (arready=1, rvalid one cycle after AR):
  - E1: AR handshake.
  - E2: R handshake; inst_valid_o=1, inst_addr_o=RESET_PC; next AR raised (m_araddr=RESET_PC+4).
  - Steady state: one instruction every 2 cycles, alternating with a bubble cycle.
- Wait states extend ADDR/DATA cycle for cycle; each adds one bubble cycle on the output.
- HOLD adds no latency: the buffered instruction appears on the first edge with stall_i=0, and its AR follows on the same edge.
- R data arriving while stall_i=1 is never lost and never presented twice.

## Test plan
- **Reset/boot:** rst low 3 cycles, RESET_PC=32'h0000_0100, zero-wait slave returning rdata=araddr^32'hA5A5_0000.
  - Expect all outputs 0 during reset.
  - ARs to 0x100, 0x104, 0x108.
  - inst_valid_o pattern 1,0,1,0 starting at E2, with inst_data_o=0xA5A5_0100, 0xA5A5_0104.
- **Wait states:** arready delayed 2 cycles, rvalid delayed 3 cycles.
  - m_araddr is stable while arvalid=1.
  - One instruction per 7-cycle window; bubbles in between carry data=0.
- **Stall in DATA:** stall_i=1 for 4 cycles spanning the R handshake of 0x10C.
  - Previous instruction (0x108) stays on the outputs throughout.
  - No AR is issued during the stall.
  - 0x10C appears on the first edge with stall_i=0, with AR for 0x110 on that same edge.
- **Error response:** rresp=2'b10 for address 0x114.
  - inst_valid_o=1, inst_data_o=0, fetch_err_o=1 for exactly one cycle.
  - Next fetch proceeds to 0x118.
- **Wrap:** RESET_PC=32'hFFFF_FFF8.
  - Fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Reset mid-transaction:** assert rst while in DATA (rready=1).
  - m_arvalid, m_rready, inst_valid_o drop asynchronously, before the next edge.
  - After release, fetching restarts at RESET_PC.
